// File: rtl/flash_audio_sequencer.sv
// Walks a flash sample region over Avalon-MM, splitting each 32-bit word into two
// signed 16-bit samples issued one per audio tick, with pause, direction and restart.
module flash_audio_sequencer #(
  parameter int                    ADDR_WIDTH = 23,
  parameter logic [ADDR_WIDTH-1:0] START_ADDR = 23'h000000,
  parameter logic [ADDR_WIDTH-1:0] END_ADDR   = 23'h07FFFF
) (
  input  logic                  inclk,
  input  logic                  reset_n,
  input  logic                  sample_tick,
  input  logic                  start_read_flash,
  input  logic                  direction,
  input  logic                  restart,
  output logic [ADDR_WIDTH-1:0] flash_mem_address,
  output logic                  flash_mem_read,
  output logic [3:0]            flash_mem_byteenable,
  input  logic                  flash_mem_waitrequest,
  input  logic [31:0]           flash_mem_readdata,
  input  logic                  flash_mem_readdatavalid,
  output logic [15:0]           audio_sample,
  output logic                  sample_valid,
  output logic                  flash_read_finished,
  output logic [2:0]            fsm_state
);

  // Avalon handshake: a read is issued by holding flash_mem_read with a stable
  // address until a cycle with waitrequest low; data returns later on readdatavalid.
  typedef enum logic [2:0] {
    S_WAIT_TICK    = 3'd0,
    S_READ         = 3'd1,
    S_WAIT_DATA    = 3'd2,
    S_EMIT         = 3'd3,
    S_RESTART      = 3'd4,
    S_RESTART_HOLD = 3'd5
  } state_t;

  state_t                state, state_n;
  logic [ADDR_WIDTH-1:0] addr_n;
  logic                  read_n, valid_n, fin_n;
  logic [15:0]           sample_n;
  logic                  half_pending, half_n;
  logic                  word_dir, wdir_n;
  logic [31:0]           word_q, word_n;
  logic                  restart_seen, rs_n;

  assign flash_mem_byteenable = 4'hF;
  assign fsm_state            = state;

  function automatic logic [ADDR_WIDTH-1:0] advance(input logic [ADDR_WIDTH-1:0] a,
                                                    input logic dir);
    if (!dir) advance = (a == END_ADDR)   ? START_ADDR : a + 1'b1;
    else      advance = (a == START_ADDR) ? END_ADDR   : a - 1'b1;
  endfunction

  always_comb begin
    state_n  = state;
    addr_n   = flash_mem_address;
    read_n   = 1'b0;
    sample_n = audio_sample;
    valid_n  = 1'b0;
    fin_n    = 1'b0;
    half_n   = half_pending;
    wdir_n   = word_dir;
    word_n   = word_q;
    rs_n     = restart_seen;
    case (state)
      S_WAIT_TICK: begin
        if (restart) begin
          state_n = S_RESTART;
        end else if (sample_tick && start_read_flash) begin
          if (half_pending) begin
            // Second half is the opposite half of the word; advance uses live direction.
            sample_n = word_dir ? word_q[15:0] : word_q[31:16];
            valid_n  = 1'b1;
            half_n   = 1'b0;
            addr_n   = advance(flash_mem_address, direction);
          end else begin
            wdir_n  = direction;
            read_n  = 1'b1;
            state_n = S_READ;
          end
        end
      end
      S_READ: begin
        rs_n = restart_seen | restart;
        if (flash_mem_waitrequest) read_n  = 1'b1;
        else                       state_n = S_WAIT_DATA;
      end
      S_WAIT_DATA: begin
        rs_n = restart_seen | restart;
        if (flash_mem_readdatavalid) begin
          if (rs_n) begin
            state_n = S_RESTART;
          end else begin
            word_n   = flash_mem_readdata;
            sample_n = word_dir ? flash_mem_readdata[31:16] : flash_mem_readdata[15:0];
            valid_n  = 1'b1;
            half_n   = 1'b1;
            state_n  = S_EMIT;
          end
        end
      end
      S_EMIT: state_n = S_WAIT_TICK;
      S_RESTART: begin
        addr_n  = direction ? END_ADDR : START_ADDR;
        half_n  = 1'b0;
        fin_n   = 1'b1;
        rs_n    = 1'b0;
        state_n = S_RESTART_HOLD;
      end
      S_RESTART_HOLD: if (!restart) state_n = S_WAIT_TICK;
      default: state_n = S_WAIT_TICK;
    endcase
  end

  always_ff @(posedge inclk) begin
    if (!reset_n) begin
      state               <= S_WAIT_TICK;
      flash_mem_address   <= START_ADDR;
      flash_mem_read      <= 1'b0;
      audio_sample        <= 16'h0000;
      sample_valid        <= 1'b0;
      flash_read_finished <= 1'b0;
      half_pending        <= 1'b0;
      word_dir            <= 1'b0;
      word_q              <= 32'h0;
      restart_seen        <= 1'b0;
    end else begin
      state               <= state_n;
      flash_mem_address   <= addr_n;
      flash_mem_read      <= read_n;
      audio_sample        <= sample_n;
      sample_valid        <= valid_n;
      flash_read_finished <= fin_n;
      half_pending        <= half_n;
      word_dir            <= wdir_n;
      word_q              <= word_n;
      restart_seen        <= rs_n;
    end
  end

endmodule

// File: tb/tb_flash_audio_sequencer.sv
// Directed bench for flash_audio_sequencer: word split, both wraps, waitrequest,
// pause, restart during a read and reset during a read.
module tb_flash_audio_sequencer;

  localparam logic [22:0] START_A = 23'h000000;
  localparam logic [22:0] END_A   = 23'h07FFFF;

  logic        inclk = 1'b0;
  logic        reset_n;
  logic        sample_tick;
  logic        start_read_flash;
  logic        direction;
  logic        restart;
  logic [22:0] flash_mem_address;
  logic        flash_mem_read;
  logic [3:0]  flash_mem_byteenable;
  logic        flash_mem_waitrequest;
  logic [31:0] flash_mem_readdata;
  logic        flash_mem_readdatavalid;
  logic [15:0] audio_sample;
  logic        sample_valid;
  logic        flash_read_finished;
  logic [2:0]  fsm_state;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 inclk = ~inclk;

  flash_audio_sequencer #(
    .ADDR_WIDTH(23), .START_ADDR(START_A), .END_ADDR(END_A)
  ) dut (
    .inclk                  (inclk),
    .reset_n                (reset_n),
    .sample_tick            (sample_tick),
    .start_read_flash       (start_read_flash),
    .direction              (direction),
    .restart                (restart),
    .flash_mem_address      (flash_mem_address),
    .flash_mem_read         (flash_mem_read),
    .flash_mem_byteenable   (flash_mem_byteenable),
    .flash_mem_waitrequest  (flash_mem_waitrequest),
    .flash_mem_readdata     (flash_mem_readdata),
    .flash_mem_readdatavalid(flash_mem_readdatavalid),
    .audio_sample           (audio_sample),
    .sample_valid           (sample_valid),
    .flash_read_finished    (flash_read_finished),
    .fsm_state              (fsm_state)
  );

  // Inputs change and outputs are sampled at the falling edge.
  task automatic step();
    @(negedge inclk);
  endtask

  task automatic tick();
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
  endtask

  // Flash slave: hold waitrequest for wr cycles, then return word one cycle after accept.
  task automatic serve(input logic [31:0] w, input int wr, output int read_cycles,
                       output bit addr_stable);
    logic [22:0] a0;
    a0 = flash_mem_address;
    read_cycles = 0;
    addr_stable = 1'b1;
    flash_mem_waitrequest = (wr > 0);
    for (int i = 0; i <= wr; i++) begin
      if (flash_mem_read) read_cycles++;
      if (flash_mem_address !== a0) addr_stable = 1'b0;
      if (i == wr) flash_mem_waitrequest = 1'b0;
      step();
    end
    flash_mem_readdata = w;
    flash_mem_readdatavalid = 1'b1;
    step();
    flash_mem_readdatavalid = 1'b0;
  endtask

  task automatic do_restart(input logic dir_v, input logic [22:0] exp_addr);
    int pulses;
    pulses = 0;
    direction = dir_v;
    restart = 1'b1;
    repeat (4) begin step(); if (flash_read_finished) pulses++; end
    restart = 1'b0;
    repeat (3) begin step(); if (flash_read_finished) pulses++; end
    total_cnt++;
    if (pulses !== 1) $display("FAIL restart_pulses: got %0d expected 1", pulses);
    else pass_cnt++;
    total_cnt++;
    if (flash_mem_address !== exp_addr)
      $display("FAIL restart_addr: got %h expected %h", flash_mem_address, exp_addr);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) step();
    total_cnt++;
    if (flash_mem_address !== START_A) $display("FAIL reset_addr: got %h expected %h", flash_mem_address, START_A);
    else pass_cnt++;
    total_cnt++;
    if ({flash_mem_read, sample_valid, flash_read_finished} !== 3'b000)
      $display("FAIL reset_strobes: got %b expected 000", {flash_mem_read, sample_valid, flash_read_finished});
    else pass_cnt++;
    total_cnt++;
    if (audio_sample !== 16'h0000) $display("FAIL reset_sample: got %h expected 0000", audio_sample);
    else pass_cnt++;
    total_cnt++;
    if (flash_mem_byteenable !== 4'hF) $display("FAIL byteenable: got %h expected f", flash_mem_byteenable);
    else pass_cnt++;
    total_cnt++;
    if (fsm_state !== 3'd0) $display("FAIL reset_state: got %0d expected 0", fsm_state);
    else pass_cnt++;
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_forward_split();
    int rc; bit st;
    start_read_flash = 1'b1;
    direction = 1'b0;
    tick();
    total_cnt++;
    if (flash_mem_read !== 1'b1) $display("FAIL fwd_read_rise: got %b expected 1", flash_mem_read);
    else pass_cnt++;
    serve(32'hBBBB_AAAA, 0, rc, st);
    total_cnt++;
    if (sample_valid !== 1'b1 || audio_sample !== 16'hAAAA)
      $display("FAIL fwd_first: got v=%b s=%h expected v=1 s=aaaa", sample_valid, audio_sample);
    else pass_cnt++;
    step();
    total_cnt++;
    if (sample_valid !== 1'b0) $display("FAIL fwd_valid_pulse: got %b expected 0", sample_valid);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (sample_valid !== 1'b1 || audio_sample !== 16'hBBBB)
      $display("FAIL fwd_second: got v=%b s=%h expected v=1 s=bbbb", sample_valid, audio_sample);
    else pass_cnt++;
    total_cnt++;
    if (flash_mem_address !== 23'd1) $display("FAIL fwd_advance: got %h expected 000001", flash_mem_address);
    else pass_cnt++;
  endtask

  task automatic test_backward_wrap();
    int rc; bit st;
    do_restart(1'b0, START_A);
    direction = 1'b1;
    tick();
    serve(32'h1234_5678, 0, rc, st);
    total_cnt++;
    if (sample_valid !== 1'b1 || audio_sample !== 16'h1234)
      $display("FAIL bwd_first: got v=%b s=%h expected v=1 s=1234", sample_valid, audio_sample);
    else pass_cnt++;
    step();
    tick();
    total_cnt++;
    if (sample_valid !== 1'b1 || audio_sample !== 16'h5678)
      $display("FAIL bwd_second: got v=%b s=%h expected v=1 s=5678", sample_valid, audio_sample);
    else pass_cnt++;
    total_cnt++;
    if (flash_mem_address !== END_A) $display("FAIL bwd_wrap: got %h expected %h", flash_mem_address, END_A);
    else pass_cnt++;
  endtask

  task automatic test_forward_wrap_wait();
    int rc; bit st;
    direction = 1'b0;
    tick();
    serve(32'hCAFE_0001, 5, rc, st);
    total_cnt++;
    if (rc !== 6) $display("FAIL wait_read_cycles: got %0d expected 6", rc);
    else pass_cnt++;
    total_cnt++;
    if (st !== 1'b1) $display("FAIL wait_addr_stable: got %b expected 1", st);
    else pass_cnt++;
    total_cnt++;
    if (audio_sample !== 16'h0001) $display("FAIL wrap_first: got %h expected 0001", audio_sample);
    else pass_cnt++;
    step();
    tick();
    total_cnt++;
    if (audio_sample !== 16'hCAFE || flash_mem_address !== START_A)
      $display("FAIL fwd_wrap: got s=%h a=%h expected s=cafe a=%h", audio_sample, flash_mem_address, START_A);
    else pass_cnt++;
  endtask

  task automatic test_pause();
    int rc; bit st; int seen;
    tick();
    serve(32'h5555_6666, 0, rc, st);
    step();
    start_read_flash = 1'b0;
    seen = 0;
    repeat (10) begin tick(); if (sample_valid) seen++; end
    total_cnt++;
    if (seen !== 0) $display("FAIL pause_valid: got %0d pulses expected 0", seen);
    else pass_cnt++;
    total_cnt++;
    if (flash_mem_address !== START_A || audio_sample !== 16'h6666)
      $display("FAIL pause_hold: got a=%h s=%h expected a=%h s=6666", flash_mem_address, audio_sample, START_A);
    else pass_cnt++;
    start_read_flash = 1'b1;
    tick();
    total_cnt++;
    if (sample_valid !== 1'b1 || audio_sample !== 16'h5555 || flash_mem_address !== 23'd1)
      $display("FAIL pause_resume: got v=%b s=%h a=%h expected v=1 s=5555 a=000001",
               sample_valid, audio_sample, flash_mem_address);
    else pass_cnt++;
  endtask

  task automatic test_restart_during_read();
    int seen, pulses;
    seen = 0; pulses = 0;
    tick();
    step();
    direction = 1'b1;
    restart = 1'b1;
    step(); if (sample_valid) seen++; if (flash_read_finished) pulses++;
    flash_mem_readdata = 32'hDEAD_BEEF;
    flash_mem_readdatavalid = 1'b1;
    step(); if (sample_valid) seen++; if (flash_read_finished) pulses++;
    flash_mem_readdatavalid = 1'b0;
    repeat (2) begin step(); if (sample_valid) seen++; if (flash_read_finished) pulses++; end
    restart = 1'b0;
    repeat (4) begin step(); if (sample_valid) seen++; if (flash_read_finished) pulses++; end
    total_cnt++;
    if (seen !== 0) $display("FAIL rst_read_valid: got %0d expected 0", seen);
    else pass_cnt++;
    total_cnt++;
    if (pulses !== 1) $display("FAIL rst_read_pulses: got %0d expected 1", pulses);
    else pass_cnt++;
    total_cnt++;
    if (flash_mem_address !== END_A || audio_sample !== 16'h5555)
      $display("FAIL rst_read_addr: got a=%h s=%h expected a=%h s=5555", flash_mem_address, audio_sample, END_A);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_read();
    direction = 1'b0;
    tick();
    flash_mem_waitrequest = 1'b1;
    step();
    total_cnt++;
    if (flash_mem_read !== 1'b1) $display("FAIL mid_read_active: got %b expected 1", flash_mem_read);
    else pass_cnt++;
    reset_n = 1'b0;
    step();
    total_cnt++;
    if (flash_mem_read !== 1'b0 || flash_mem_address !== START_A || audio_sample !== 16'h0000)
      $display("FAIL mid_reset: got r=%b a=%h s=%h expected r=0 a=%h s=0000",
               flash_mem_read, flash_mem_address, audio_sample, START_A);
    else pass_cnt++;
    reset_n = 1'b1;
    flash_mem_waitrequest = 1'b0;
    flash_mem_readdata = 32'h1111_2222;
    flash_mem_readdatavalid = 1'b1;
    step();
    flash_mem_readdatavalid = 1'b0;
    total_cnt++;
    if (sample_valid !== 1'b0) $display("FAIL stray_valid: got %b expected 0", sample_valid);
    else pass_cnt++;
    step();
    total_cnt++;
    if (fsm_state !== 3'd0 || flash_mem_read !== 1'b0)
      $display("FAIL stray_state: got st=%0d r=%b expected st=0 r=0", fsm_state, flash_mem_read);
    else pass_cnt++;
  endtask

  initial begin
    reset_n = 1'b0;
    sample_tick = 1'b0;
    start_read_flash = 1'b0;
    direction = 1'b0;
    restart = 1'b0;
    flash_mem_waitrequest = 1'b0;
    flash_mem_readdata = 32'h0;
    flash_mem_readdatavalid = 1'b0;
    test_reset();
    test_forward_split();
    test_backward_wrap();
    test_forward_wrap_wait();
    test_pause();
    test_restart_during_read();
    test_reset_mid_read();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
